// File: rtl/calculator.sv
// calculator: registered 8-bit add/sub/mul unit with sign-magnitude output.
// Define CALC_DIV_EN to make OP=11 a combinational divide; otherwise OP=11 yields zero.
module calculator #(
  parameter int OPW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2*OPW+1:0] DIN,
  output logic [2*OPW-1:0] RESULT,
  output logic             NEG
);
  logic [1:0]       op;
  logic [OPW-1:0]   a, b;
  logic [2*OPW-1:0] sum, diff, prod, quo, result_d, result_q;
  logic             neg_d, neg_q;
  assign op = DIN[2*OPW+1:2*OPW];
  assign a  = DIN[2*OPW-1:OPW];
  assign b  = DIN[OPW-1:0];
  always_comb begin
    sum  = (2*OPW)'(a) + (2*OPW)'(b);
    diff = (2*OPW)'(a >= b ? a - b : b - a);
    prod = (2*OPW)'(a) * (2*OPW)'(b);
`ifdef CALC_DIV_EN
    quo  = b == '0 ? '1 : {a / b, a % b};
`else
    quo  = '0;
`endif
    result_d = op == 2'd0 ? sum : op == 2'd1 ? diff : op == 2'd2 ? prod : quo;
    // magnitude is already folded into diff, so equal operands never flag negative
    neg_d    = op == 2'd1 && a < b;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      neg_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      neg_q    <= neg_d;
    end
  end
  assign RESULT = result_q;
  assign NEG    = neg_q;
endmodule

// File: tb/tb_calculator.sv
// tb_calculator: directed and random checks of calculator against an arithmetic reference model.
module tb_calculator;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [17:0] DIN = '0;
  logic [15:0] RESULT;
  logic        NEG;
  int checks = 0;
  int errors = 0;

  calculator dut (.clk(clk), .reset(reset), .DIN(DIN), .RESULT(RESULT), .NEG(NEG));

  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [17:0] d);
    int a = int'(d[15:8]);
    int b = int'(d[7:0]);
    int r;
    bit n = 1'b0;
    case (d[17:16])
      2'd0: r = a + b;
      2'd1: begin r = (a >= b) ? a - b : b - a; n = a < b; end
      2'd2: r = a * b;
`ifdef CALC_DIV_EN
      default: r = (b == 0) ? 65535 : (a / b) * 256 + (a % b);
`else
      default: r = 0;
`endif
    endcase
    return {n, 16'(r)};
  endfunction

  task automatic compare(input string tag, input logic [16:0] exp);
    checks++;
    assert ({NEG, RESULT} === exp)
    else begin
      errors++;
      $error("FAIL %s got NEG=%b RESULT=%h exp NEG=%b RESULT=%h", tag, NEG, RESULT, exp[16], exp[15:0]);
    end
  endtask

  task automatic step(input string tag, input logic [17:0] d);
    @(negedge clk);
    DIN = d;
    @(posedge clk);
    #1 compare(tag, model(d));
  endtask

  task automatic step_exp(input string tag, input logic [17:0] d, input logic [16:0] exp);
    @(negedge clk);
    DIN = d;
    @(posedge clk);
    #1 compare(tag, exp);
  endtask

  logic [17:0] last;
  logic [16:0] held;

  initial begin
    DIN = 18'h0_00_5D;
    @(posedge clk);
    #1 compare("reset", 17'h0_0000);
    @(negedge clk);
    reset = 1'b0;
    step_exp("add1", 18'h0_00_5D, 17'h0_005D);
    step_exp("add2", 18'h0_C2_F6, 17'h0_01B8);
    step_exp("add3", 18'h0_55_AA, 17'h0_00FF);
    step_exp("addmax", 18'h0_FF_FF, 17'h0_01FE);
    step_exp("sub1", 18'h1_CC_00, 17'h0_00CC);
    step_exp("sub2", 18'h1_36_9B, 17'h1_0065);
    step_exp("sub3", 18'h1_12_07, 17'h0_000B);
    step_exp("sub_eq", 18'h1_40_40, 17'h0_0000);
    step_exp("sub_min", 18'h1_00_FF, 17'h1_00FF);
    step_exp("mul1", 18'h2_86_59, 17'h0_2E96);
    step_exp("mul2", 18'h2_D0_00, 17'h0_0000);
    step_exp("mul3", 18'h2_00_00, 17'h0_0000);
    step_exp("mulmax", 18'h2_FF_FF, 17'h0_FE01);
`ifdef CALC_DIV_EN
    step_exp("div1", 18'h3_C8_07, 17'h0_1C04);
    step_exp("div0", 18'h3_05_00, 17'h0_FFFF);
`else
    step_exp("rsv1", 18'h3_C8_07, 17'h0_0000);
    step_exp("rsv2", 18'h3_05_00, 17'h0_0000);
`endif
    @(negedge clk);
    reset = 1'b1;
    DIN = 18'h1_36_9B;
    @(posedge clk);
    #1 compare("mid_reset", 17'h0_0000);
    @(negedge clk);
    reset = 1'b0;
    step_exp("post_reset", 18'h0_01_01, 17'h0_0002);
    for (int i = 0; i < 9; i++) begin
      last = {2'(i % 4), 16'($urandom)};
      step("b2b", last);
    end
    for (int i = 0; i < 40; i++) step("rand", 18'($urandom));
    last = {2'($urandom_range(0, 3)), 16'($urandom)};
    step("hold_first", last);
    held = model(last);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1 compare("hold", held);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
